// File: rtl/div_pkg.sv
// Shared types and constants for the parametrised restoring divider.
// Holds the FSM state encoding and the field positions inside the {remainder, quotient} result word.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BYZERO,
    ON,
    END
  } div_state_e;

  localparam int QUOT_LSB = 0;

  // The remainder starts right above the quotient, whatever the operand width.
  function automatic int rem_lsb(input int width);
    return width;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when the shifted partial remainder can take it.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The compare is one bit wider than the operands, so the shifted-out MSB
  // still counts. The difference is always below the divisor, so WIDTH bits hold it.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted[WIDTH-1:0] - dvs_i;
    if (shifted >= {1'b0, dvs_i}) begin
      rem_o   = diff;
      q_bit_o = 1'b1;
    end else begin
      rem_o   = shifted[WIDTH-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_param.sv
// Multi-cycle signed/unsigned restoring divider for the EX-stage HI/LO path.
// It latches operands at start, iterates over the magnitudes, then applies the sign fix-up on entry to END.
module div_param
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               dbz_o,
  output logic               ovf_o
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam int               REM_LSB  = rem_lsb(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend magnitude, becomes the quotient as it shifts
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   q_final, r_final;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_comb begin
    accept  = (state_q == IDLE) && start_i && !annul_i;
    mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
    mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;
    q_final = {dvd_q[WIDTH-2:0], step_q};
    r_final = step_rem;
  end

  // NOTE: every signal assigned below gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    ovf_pend_d = ovf_pend_q;
    result_d   = result_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dvd_d      = mag1;
          dvs_d      = mag2;
          rem_d      = '0;
          cnt_d      = '0;
          sign_q_d   = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          sign_r_d   = signed_div_i & opdata1_i[WIDTH-1];
          ovf_pend_d = signed_div_i && (opdata1_i == MIN_NEG) && (opdata2_i == ALL_ONES);
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else if (EARLY_OUT && (mag2 > mag1)) begin
            // Zero quotient: the raw dividend is already the signed remainder.
            state_d                      = END;
            result_d[QUOT_LSB +: WIDTH]  = '0;
            result_d[REM_LSB +: WIDTH]   = opdata1_i;
            dbz_d                        = 1'b0;
            ovf_d                        = 1'b0;
          end else begin
            state_d = ON;
          end
        end
      end
      BYZERO: begin
        state_d  = END;
        result_d = '0;
        dbz_d    = 1'b1;
        ovf_d    = 1'b0;
      end
      ON: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = q_final;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d                     = END;
            result_d[QUOT_LSB +: WIDTH] = sign_q_q ? negate(q_final) : q_final;
            result_d[REM_LSB +: WIDTH]  = sign_r_q ? negate(r_final) : r_final;
            dbz_d                       = 1'b0;
            ovf_d                       = ovf_pend_q;
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the datapath registers are reset too, so a reset mid-divide leaves no stale flags or result visible.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      ovf_pend_q <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      sign_q_q   <= sign_q_d;
      sign_r_q   <= sign_r_d;
      ovf_pend_q <= ovf_pend_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == END);
  assign busy_o   = (state_q != IDLE);
  assign dbz_o    = dbz_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_div_param.sv
// Directed bench for div_param: a 32-bit instance for most cases and an 8-bit one for the width check.
// Inputs change 1 time unit after the rising edge, and outputs are sampled at that same point.
module tb_div_param;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        signed_div, start, annul;
  logic [31:0] op1, op2;
  logic [63:0] result32;
  logic        ready32, busy32, dbz32, ovf32;

  logic        sd8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        ready8, busy8, dbz8, ovf8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_param #(.WIDTH(32), .EARLY_OUT(1'b1)) u_dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result32),
    .ready_o      (ready32),
    .busy_o       (busy32),
    .dbz_o        (dbz32),
    .ovf_o        (ovf32)
  );

  div_param #(.WIDTH(8), .EARLY_OUT(1'b1)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .signed_div_i (sd8),
    .opdata1_i    (a8),
    .opdata2_i    (b8),
    .start_i      (start8),
    .annul_i      (annul8),
    .result_o     (res8),
    .ready_o      (ready8),
    .busy_o       (busy8),
    .dbz_o        (dbz8),
    .ovf_o        (ovf8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one divide, scramble the operand inputs after acceptance, then
  // measure latency and check busy, the result fields and the flags.
  task automatic run(input bit use8, input bit sd, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                     input logic eovf, input int elat, input string tag);
    int          lat;
    bit          busy_ok;
    logic [31:0] q_obs, r_obs;
    if (use8) begin
      sd8 = sd; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      signed_div = sd; op1 = a; op2 = b; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; start8 = 1'b0;
    op1 = ~a; op2 = ~b; a8 = ~a[7:0]; b8 = ~b[7:0];
    lat = 1;
    busy_ok = 1'b1;
    while (!(use8 ? ready8 : ready32) && lat < 100) begin
      if (!(use8 ? busy8 : busy32)) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    q_obs = use8 ? {24'h0, res8[7:0]}  : result32[31:0];
    r_obs = use8 ? {24'h0, res8[15:8]} : result32[63:32];
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " busy_during"}, {63'h0, busy_ok}, 64'h1);
    check({tag, " busy_at_ready"}, {63'h0, use8 ? busy8 : busy32}, 64'h1);
    check({tag, " quotient"}, {32'h0, q_obs}, {32'h0, eq});
    check({tag, " remainder"}, {32'h0, r_obs}, {32'h0, er});
    check({tag, " dbz"}, {63'h0, use8 ? dbz8 : dbz32}, {63'h0, edbz});
    check({tag, " ovf"}, {63'h0, use8 ? ovf8 : ovf32}, {63'h0, eovf});
    @(posedge clk); #1;
    check({tag, " ready_pulse"}, {63'h0, use8 ? ready8 : ready32}, 64'h0);
    check({tag, " idle_after"}, {63'h0, use8 ? busy8 : busy32}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_ready;
    rst_n = 1'b0;
    signed_div = 1'b0; start = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
    sd8 = 1'b0; start8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;
    #3;
    check("reset result32", result32, 64'h0);
    check("reset flags32", {60'h0, ready32, busy32, dbz32, ovf32}, 64'h0);
    check("reset result8", {48'h0, res8}, 64'h0);
    check("reset flags8", {60'h0, ready8, busy8, dbz8, ovf8}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, "u100_7");
    run(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, "s-7_2");
    run(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 33, "s7_-2");
    run(1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 2, "u5_0");
    run(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33, "u9_3");
    run(1'b0, 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b0, 1, "early_u3_10");
    run(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1, "early_s-3_10");
    run(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 33, "ovf");

    // start held through END: not taken in END, taken in the following IDLE
    signed_div = 1'b0; op1 = 32'd3; op2 = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    check("held first_ready", {63'h0, ready32}, 64'h1);
    @(posedge clk); #1;
    check("held idle_gap", {62'h0, ready32, busy32}, 64'h0);
    @(posedge clk); #1;
    check("held second_ready", {63'h0, ready32}, 64'h1);
    start = 1'b0;
    @(posedge clk); #1;
    check("held released", {62'h0, ready32, busy32}, 64'h0);

    // annul 10 cycles into 1000/3, after the overflow result is in place
    run(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 33, "ovf_again");
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_ready = ready32;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      saw_ready |= ready32;
    end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul no_ready", {63'h0, saw_ready | ready32}, 64'h0);
    check("annul busy_low", {63'h0, busy32}, 64'h0);
    check("annul result_held", result32, 64'h0000_0000_8000_0000);
    check("annul ovf_held", {63'h0, ovf32}, 64'h1);
    run(1'b0, 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 33, "restart1000_3");

    // asynchronous reset in the middle of a divide
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("pre_reset busy", {63'h0, busy32}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset result", result32, 64'h0);
    check("midreset flags", {60'h0, ready32, busy32, dbz32, ovf32}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run(1'b1, 1'b0, 32'd200, 32'd7, 32'd28, 32'd4, 1'b0, 1'b0, 9, "w8_200_7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
